adder_nibble_seq: RTL and testbench



---
 rtl/adder_nibble_seq.sv | 147 ++++++++++++++
 tb/tb_adder_nibble_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_nibble_seq.sv
// Nibble-serial wide add/subtract sequencer built around one shared 4-bit
// prefix adder. It takes operands over req_*, returns the result over rsp_*.

module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] w_g, w_p;
  logic       w_g10, w_p10, w_g32, w_p32, w_g30, w_p30;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Brent-Kung style group generate/propagate tree
  assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
  assign w_p10 = w_p[1] & w_p[0];
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];
  assign w_g30 = w_g32 | (w_p32 & w_g10);
  assign w_p30 = w_p32 & w_p10;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g10 | (w_p10 & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
  assign w_c[4] = w_g30 | (w_p30 & cin);

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];
endmodule

module adder_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_cin,
  input  logic                 req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic                 busy
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [W-1:0]       r_a_sr, r_b_sr, r_res_sr;
  logic [W-1:0]       w_a_shift, w_b_shift, w_res_next, w_b_eff;
  logic               r_carry, r_a_msb, r_b_msb;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         w_add_sum;
  logic               w_add_cout, w_accept, w_last;

  adder u_adder (
    .a    (r_a_sr[3:0]),
    .b    (r_b_sr[3:0]),
    .cin  (r_carry),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  assign w_b_eff  = req_sub ? ~req_b : req_b;
  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(NIBBLES - 1));

  // A single-nibble build has no upper slice to shift from.
  generate
    if (NIBBLES == 1) begin : g_one
      assign w_res_next = w_add_sum;
      assign w_a_shift  = '0;
      assign w_b_shift  = '0;
    end else begin : g_many
      assign w_res_next = {w_add_sum, r_res_sr[W-1:4]};
      assign w_a_shift  = {4'b0, r_a_sr[W-1:4]};
      assign w_b_shift  = {4'b0, r_b_sr[W-1:4]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: next state defaults to the current state so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (rsp_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= req_a;
      r_b_sr   <= w_b_eff;
      r_carry  <= req_sub ? 1'b1 : req_cin;
      r_cnt    <= '0;
      r_a_msb  <= req_a[W-1];
      r_b_msb  <= w_b_eff[W-1];
    end else if (r_state == S_RUN) begin
      r_a_sr   <= w_a_shift;
      r_b_sr   <= w_b_shift;
      r_res_sr <= w_res_next;
      r_carry  <= w_add_cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        rsp_sum  <= w_res_next;
        rsp_cout <= w_add_cout;
        rsp_ovf  <= (r_a_msb == r_b_msb) && (w_add_sum[3] != r_a_msb);
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_adder_nibble_seq.sv
// Directed self-checking bench for adder_nibble_seq (NIBBLES=4 main instance,
// plus a NIBBLES=1 instance for the single-cycle RUN corner).

module tb_adder_nibble_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_cin, req_sub;
  logic [15:0] req_a, req_b, rsp_sum;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf, busy;

  logic        d1_req_valid, d1_req_ready, d1_rsp_valid, d1_rsp_ready;
  logic        d1_rsp_cout, d1_rsp_ovf, d1_busy;
  logic [3:0]  d1_req_a, d1_req_b, d1_rsp_sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  adder_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(d1_req_valid), .req_ready(d1_req_ready),
    .req_a(d1_req_a), .req_b(d1_req_b), .req_cin(1'b0), .req_sub(1'b0),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready),
    .rsp_sum(d1_rsp_sum), .rsp_cout(d1_rsp_cout), .rsp_ovf(d1_rsp_ovf),
    .busy(d1_busy)
  );

  typedef struct {
    string       name;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request at the falling edge and hold it until the accepting edge.
  task automatic send(input vec_t v);
    @(negedge clk);
    req_a = v.a; req_b = v.b; req_cin = v.cin; req_sub = v.sub; req_valid = 1'b1;
    check({v.name, " req_ready before accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
  endtask

  // Count falling edges after the accepting edge until rsp_valid appears.
  task automatic wait_rsp(input string name, output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      cycles++;
      if (rsp_valid) return;
    end
    check({name, " rsp_valid timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_rsp(input vec_t v);
    check({v.name, " sum"},  32'(rsp_sum),  32'(v.sum));
    check({v.name, " cout"}, 32'(rsp_cout), 32'(v.cout));
    check({v.name, " ovf"},  32'(rsp_ovf),  32'(v.ovf));
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int   lat;
    vec_t bp_next, rst_op;
    logic [15:0] held_sum;
    logic        held_cout, held_ovf, saw_rsp;

    vecs[0] = '{"add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"sub_0005_0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub_8000_0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{"addc_7fff_0000", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{"sub_cin_ignored", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{"addc_a5a5_5a5a", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    bp_next = '{"bp_next", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0};
    rst_op  = '{"after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cin = 1'b0; req_sub = 1'b0;
    d1_req_valid = 1'b0; d1_rsp_ready = 1'b0; d1_req_a = '0; d1_req_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset outputs",   {13'd0, rsp_ovf, rsp_cout, rsp_sum}, 32'd0);

    // Table-driven vectors with latency and handshake spacing checks.
    foreach (vecs[i]) begin
      send(vecs[i]);
      @(negedge clk);
      req_valid = 1'b0;
      check({vecs[i].name, " busy in RUN"}, 32'(busy), 32'd1);
      wait_rsp(vecs[i].name, lat);
      lat++;
      check({vecs[i].name, " latency"}, 32'(lat), 32'd5);
      check_rsp(vecs[i]);
      take_rsp();
      check({vecs[i].name, " idle after rsp"}, 32'(req_ready), 32'd1);
    end

    // Backpressure: response held while a new request waits.
    send(vecs[0]);
    wait_rsp("bp", lat);
    req_a = bp_next.a; req_b = bp_next.b; req_cin = 1'b0; req_sub = 1'b0;
    req_valid = 1'b1;
    held_sum = rsp_sum; held_cout = rsp_cout; held_ovf = rsp_ovf;
    check_rsp(vecs[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp rsp_valid held", 32'(rsp_valid), 32'd1);
      check("bp req_ready low",  32'(req_ready), 32'd0);
      check("bp outputs stable", {15'd0, rsp_ovf, rsp_cout, rsp_sum},
            {15'd0, held_ovf, held_cout, held_sum});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp idle after rsp", 32'(req_ready), 32'd1);
    check("bp no rsp_valid",   32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp next accepted", 32'(busy), 32'd1);
    wait_rsp("bp_next", lat);
    lat++;
    check("bp_next latency", 32'(lat), 32'd5);
    check_rsp(bp_next);
    take_rsp();

    // Reset during the second RUN cycle discards the operation.
    send(vecs[0]);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-run rst req_ready", 32'(req_ready), 32'd1);
    check("mid-run rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid-run rst busy",      32'(busy),      32'd0);
    check("mid-run rst outputs",   {13'd0, rsp_ovf, rsp_cout, rsp_sum}, 32'd0);
    saw_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
    end
    check("mid-run rst no response", 32'(saw_rsp), 32'd0);
    send(rst_op);
    wait_rsp(rst_op.name, lat);
    check_rsp(rst_op);
    take_rsp();

    // Reset while a response is pending in DONE.
    send(vecs[3]);
    wait_rsp("done_rst", lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("done rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("done rst outputs",   {13'd0, rsp_ovf, rsp_cout, rsp_sum}, 32'd0);

    // NIBBLES=1: RUN lasts one cycle, rsp_valid two cycles after accept.
    @(negedge clk);
    d1_req_a = 4'h9; d1_req_b = 4'h8; d1_req_valid = 1'b1;
    check("n1 req_ready", 32'(d1_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    d1_req_valid = 1'b0;
    check("n1 busy in RUN", 32'(d1_busy),      32'd1);
    check("n1 no early rsp", 32'(d1_rsp_valid), 32'd0);
    @(negedge clk);
    check("n1 rsp_valid", 32'(d1_rsp_valid), 32'd1);
    check("n1 result", {26'd0, d1_rsp_ovf, d1_rsp_cout, d1_rsp_sum}, {26'd0, 1'b1, 1'b1, 4'h1});
    d1_rsp_ready = 1'b1;
    @(negedge clk);
    d1_rsp_ready = 1'b0;
    check("n1 idle after rsp", 32'(d1_req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
